// File: rtl/seven_seg_scan.sv
// Purpose : scans a multiplexed common-anode 7-segment display, one digit per refresh tick.
// Latency : outputs registered; a digit lights BLANK_CYC+1 clocks after the tick that selects it.
// Backpr. : none; tick is a free-running strobe, dropped while enable=0.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   tick            one-cycle refresh-counter wrap pulse, advances the scan
//   enable          0 = display dark and scan frozen
//   value, dp_in    hex nibble / decimal-point request per digit (nibble i -> digit i)
//   an, seg, dp     active-low anode selects, {g,f,e,d,c,b,a} segments, decimal point
//   frame_start     one-cycle pulse when the scan returns to digit 0
module seven_seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int BLANK_CYC  = 16,
  parameter bit LZ_BLANK   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int               IDX_W      = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]       BLANK_LOAD = 8'(BLANK_CYC);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Active-high {g,f,e,d,c,b,a} hex font; inverted at the pins.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  // State
  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [7:0]              r_blank_cnt;
  logic [4*NUM_DIGITS-1:0] r_snap;
  logic [NUM_DIGITS-1:0]   r_snap_dp;
  // Cleared by reset so the display stays dark until the scan has been
  // started by a tick (the reset snapshot is not real data).
  logic                    r_armed;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic                    r_frame_start;

  // Next-state values
  state_t                  w_state_nxt;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [7:0]              w_blank_cnt_nxt;
  logic [4*NUM_DIGITS-1:0] w_snap_nxt;
  logic [NUM_DIGITS-1:0]   w_snap_dp_nxt;
  logic                    w_armed_nxt;
  logic                    w_frame_start_nxt;
  logic [NUM_DIGITS-1:0]   w_an_nxt;
  logic [6:0]              w_seg_nxt;
  logic                    w_dp_nxt;

  // Output decode helpers
  logic [3:0]              w_nib;
  logic                    w_nib_dp;
  logic [IDX_W-1:0]        w_top;
  logic                    w_lz_dark;

  // Scan control. A tick wins over everything except enable=0; the blank
  // counter keeps draining while disabled so re-enable can light the
  // current digit as soon as the counter is empty.
  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_blank_cnt_nxt   = (r_blank_cnt != 8'd0) ? (r_blank_cnt - 8'd1) : r_blank_cnt;
    w_snap_nxt        = r_snap;
    w_snap_dp_nxt     = r_snap_dp;
    w_armed_nxt       = r_armed;
    w_frame_start_nxt = 1'b0;

    if (!enable) begin
      w_state_nxt = ST_BLANK;
    end else if (tick) begin
      w_idx_nxt       = (r_idx == IDX_LAST) ? '0 : (r_idx + IDX_W'(1));
      w_state_nxt     = ST_BLANK;
      w_blank_cnt_nxt = BLANK_LOAD;
      w_armed_nxt     = 1'b1;
      // Frame boundary: freeze the data for the whole next frame.
      if (r_idx == IDX_LAST) begin
        w_snap_nxt        = value;
        w_snap_dp_nxt     = dp_in;
        w_frame_start_nxt = 1'b1;
      end
    end else if (r_state == ST_BLANK && r_blank_cnt == 8'd0 && r_armed) begin
      w_state_nxt = ST_DRIVE;
    end
  end

  // Output patterns are computed from the next state so that an/seg/dp
  // change on the same edge as the state register.
  always_comb begin
    w_nib    = 4'h0;
    w_nib_dp = 1'b0;
    w_top    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_snap_nxt[4*i +: 4] != 4'h0) begin
        w_top = IDX_W'(i);
      end
      if (w_idx_nxt == IDX_W'(i)) begin
        w_nib    = w_snap_nxt[4*i +: 4];
        w_nib_dp = w_snap_dp_nxt[i];
      end
    end
    // Digits above the most significant nonzero nibble are dark; digit 0
    // always shows because w_top never goes below 0.
    w_lz_dark = LZ_BLANK && (w_idx_nxt > w_top);

    w_an_nxt  = '1;
    w_seg_nxt = 7'h7F;
    w_dp_nxt  = 1'b1;
    if (w_state_nxt == ST_DRIVE && !w_lz_dark) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_idx_nxt == IDX_W'(i)) begin
          w_an_nxt[i] = 1'b0;
        end
      end
      w_seg_nxt = ~hex_decode(w_nib);
      w_dp_nxt  = ~w_nib_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BLANK;
      r_idx         <= '0;
      r_blank_cnt   <= 8'd0;
      r_snap        <= '0;
      r_snap_dp     <= '0;
      r_armed       <= 1'b0;
      r_an          <= '1;
      r_seg         <= 7'h7F;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_blank_cnt   <= w_blank_cnt_nxt;
      r_snap        <= w_snap_nxt;
      r_snap_dp     <= w_snap_dp_nxt;
      r_armed       <= w_armed_nxt;
      r_an          <= w_an_nxt;
      r_seg         <= w_seg_nxt;
      r_dp          <= w_dp_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Purpose : self-checking bench for seven_seg_scan (4 digits, 16 blank clocks, leading-zero blanking).
// Latency : expected digit outputs queued at each tick, compared once the blank interval ends.
// Backpr. : n/a.
module tb_seven_seg_scan;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  seven_seg_scan #(
    .NUM_DIGITS (4),
    .BLANK_CYC  (16),
    .LZ_BLANK   (1'b1)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .enable      (enable),
    .value       (value),
    .dp_in       (dp_in),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    bit         dark;
  } exp_t;

  exp_t sb[$];

  int n_tests;
  int n_fail;

  // Reference model of the scan position and frame snapshot.
  int          m_idx;
  logic [15:0] m_snap;
  logic [3:0]  m_sdp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic exp_t mk_exp();
    exp_t       e;
    int         k;
    logic [3:0] nib;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_snap[4*i +: 4] != 4'h0) k = i;
    end
    nib    = m_snap[4*m_idx +: 4];
    e.dark = (m_idx > k);
    e.an   = 4'hF;
    e.seg  = 7'h7F;
    e.dp   = 1'b1;
    if (!e.dark) begin
      e.an[m_idx] = 1'b0;
      e.seg       = ~FONT[nib];
      e.dp        = ~m_sdp[m_idx];
    end
    return e;
  endfunction

  // Advance the model by one accepted tick; returns whether a frame starts.
  function automatic bit model_tick();
    m_idx = (m_idx == 3) ? 0 : m_idx + 1;
    if (m_idx == 0) begin
      m_snap = value;
      m_sdp  = dp_in;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic pop_cmp(input string tag, output exp_t e);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.dark = 1'b1;
    end else begin
      e = sb.pop_front();
      chk({tag, "_an"},  {28'd0, an},  {28'd0, e.an});
      chk({tag, "_seg"}, {25'd0, seg}, {25'd0, e.seg});
      chk({tag, "_dp"},  {31'd0, dp},  {31'd0, e.dp});
    end
  endtask

  // One tick: push expectation, check frame_start pulse, blank length, digit, hold.
  task automatic do_tick(input string tag, input int idle);
    bit   fs_exp;
    exp_t e;
    int   n;
    fs_exp = model_tick();
    sb.push_back(mk_exp());
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    chk({tag, "_fs"}, {31'd0, frame_start}, {31'd0, fs_exp});
    chk({tag, "_an_blank"}, {28'd0, an}, 32'hF);
    @(negedge clk);
    chk({tag, "_fs_once"}, {31'd0, frame_start}, 32'd0);
    if (!sb[sb.size()-1].dark) begin
      n = 1;
      while (an == 4'hF && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk({tag, "_blank_len"}, n, 32'd17);
    end else begin
      repeat (30) @(negedge clk);
    end
    pop_cmp(tag, e);
    repeat (idle) @(negedge clk);
    chk({tag, "_hold_an"}, {28'd0, an}, {28'd0, e.an});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   bad_an;
    int   bad_fs;
    int   n;
    exp_t e;
    bit   fs_unused;

    n_tests = 0;
    n_fail  = 0;
    m_idx   = 0;
    m_snap  = '0;
    m_sdp   = '0;
    rst_n   = 1'b0;
    tick    = 1'b0;
    enable  = 1'b1;
    value   = 16'h1234;
    dp_in   = 4'b0000;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_an",  {28'd0, an},  32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp",  {31'd0, dp},  32'd1);
    chk("rst_fs",  {31'd0, frame_start}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("dark_before_tick", {28'd0, an}, 32'hF);

    // Priming frame: snapshot is zero, so digits 1..3 stay dark; wrap captures 1234.
    for (int i = 0; i < 4; i++) do_tick("prime", 40);
    // Frame with 1234; value/dp change mid-frame must not show before the wrap.
    do_tick("f1_d1", 40);
    do_tick("f1_d2", 40);
    value = 16'hABCD;
    dp_in = 4'b1010;
    do_tick("f1_d3", 40);
    do_tick("f1_d0", 40);
    do_tick("f2_d1", 40);

    // Two ticks 5 clocks apart: blank interval restarts from the second.
    fs_unused = model_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (3) @(negedge clk);
    do_tick("dbl_tick", 40);

    // Disabled for 1000 clocks with ticks present.
    @(negedge clk); enable = 1'b0;
    bad_an = 0;
    bad_fs = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (an != 4'hF) bad_an++;
      if (frame_start) bad_fs++;
      tick = ((i % 100) == 50);
    end
    tick = 1'b0;
    chk("dis_an_lit", bad_an, 32'd0);
    chk("dis_fs",     bad_fs, 32'd0);
    sb.push_back(mk_exp());
    enable = 1'b1;
    n = 0;
    while (an == 4'hF && n < 50) begin
      @(negedge clk);
      n++;
    end
    pop_cmp("reenable", e);

    // Leading-zero blanking.
    value = 16'h0005;
    dp_in = 4'b0000;
    do_tick("lz5_d0", 40);
    for (int i = 0; i < 3; i++) do_tick("lz5_hi", 10);
    value = 16'h0000;
    do_tick("lz0_d0", 40);
    value = 16'h1234;
    for (int i = 0; i < 3; i++) do_tick("lz0_hi", 10);
    do_tick("re_d0", 40);
    do_tick("re_d1", 40);
    do_tick("re_d2", 40);

    // Reset during DRIVE on digit 2: outputs dark without waiting for a clock.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an",  {28'd0, an},  32'hF);
    chk("mid_rst_seg", {25'd0, seg}, 32'h7F);
    chk("mid_rst_dp",  {31'd0, dp},  32'd1);
    m_idx  = 0;
    m_snap = '0;
    m_sdp  = '0;
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_dark", {28'd0, an}, 32'hF);
    // First tick goes to digit 1; frame wraps on the fourth with 1234.
    for (int i = 0; i < 4; i++) do_tick("post_rst", 30);
    do_tick("post_rst_d1", 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
